// File: rtl/pipelined_adder_switch.sv
// Adder-tree node: picks two lanes, then adds, forwards or emits them as VN outputs, or accumulates
// a multi-beat group. Results travel an elastic ADD_LAT-stage pipeline with full backpressure.
module pipelined_adder_switch #(
    parameter int DATA_W  = 32,
    parameter int NUM_IN  = 4,
    parameter int SEL_W   = $clog2(NUM_IN),
    parameter int ADD_LAT = 2
) (
    input  logic                       CLK,
    input  logic                       rst_n,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [NUM_IN*DATA_W-1:0]   i_data_bus,
    input  logic [SEL_W-1:0]           i_sel_l,
    input  logic [SEL_W-1:0]           i_sel_r,
    input  logic [2:0]                 i_cmd,
    input  logic                       i_last,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [2*DATA_W-1:0]        o_adder,
    output logic [1:0]                 o_adder_valid,
    output logic [2*DATA_W-1:0]        o_vn,
    output logic [1:0]                 o_vn_valid,
    output logic                       o_ovf
);

    // Stage 0 captures the accepted beat; stage LAST drives the outputs.
    localparam int NS   = ADD_LAT + 1;
    localparam int LAST = ADD_LAT;

    logic [DATA_W-1:0] op_a, op_b, sum_ab, acc_sum;
    logic              ovf_ab, ovf_acc, accept;

    logic [DATA_W-1:0] acc_q, acc_d;
    logic              sticky_q, sticky_d;

    logic [2*DATA_W-1:0] in_add, in_vn;
    logic [1:0]          in_av, in_vv;
    logic                in_ovf;

    logic [2*DATA_W-1:0] add_q [NS];
    logic [2*DATA_W-1:0] add_d [NS];
    logic [2*DATA_W-1:0] vn_q  [NS];
    logic [2*DATA_W-1:0] vn_d  [NS];
    logic [1:0]          av_q  [NS];
    logic [1:0]          av_d  [NS];
    logic [1:0]          vv_q  [NS];
    logic [1:0]          vv_d  [NS];
    logic [NS-1:0]       ovf_q, ovf_d;
    logic [NS-1:0]       stage_vld, stage_rdy;

    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (i_sel_l == SEL_W'(k)) op_a = i_data_bus[k*DATA_W +: DATA_W];
            if (i_sel_r == SEL_W'(k)) op_b = i_data_bus[k*DATA_W +: DATA_W];
        end
    end

    assign sum_ab  = op_a + op_b;
    assign ovf_ab  = (op_a[DATA_W-1] == op_b[DATA_W-1]) && (sum_ab[DATA_W-1] != op_a[DATA_W-1]);
    assign acc_sum = acc_q + sum_ab;
    assign ovf_acc = (acc_q[DATA_W-1] == sum_ab[DATA_W-1]) &&
                     (acc_sum[DATA_W-1] != acc_q[DATA_W-1]);
    assign accept  = i_valid && o_ready;

    // Beats with no valid field become zero-payload bubbles.
    always_comb begin
        in_add   = '0;
        in_av    = '0;
        in_vn    = '0;
        in_vv    = '0;
        in_ovf   = 1'b0;
        acc_d    = acc_q;
        sticky_d = sticky_q;
        if (accept) begin
            case (i_cmd)
                3'b001: begin
                    in_add = {op_a, op_b};
                    in_av  = 2'b11;
                end
                3'b010: begin
                    in_add = {sum_ab, sum_ab};
                    in_av  = 2'b11;
                    in_ovf = ovf_ab;
                end
                3'b011: begin
                    in_vn  = {{DATA_W{1'b0}}, op_a};
                    in_vv  = 2'b01;
                    in_add = {{DATA_W{1'b0}}, op_b};
                    in_av  = 2'b01;
                end
                3'b100: begin
                    in_vn  = {op_b, {DATA_W{1'b0}}};
                    in_vv  = 2'b10;
                    in_add = {op_a, {DATA_W{1'b0}}};
                    in_av  = 2'b10;
                end
                3'b101: begin
                    in_vn = {op_a, op_b};
                    in_vv = 2'b11;
                end
                3'b110: begin
                    if (i_last) begin
                        in_add   = {acc_sum, acc_sum};
                        in_av    = 2'b11;
                        in_ovf   = sticky_q | ovf_ab | ovf_acc;
                        acc_d    = '0;
                        sticky_d = 1'b0;
                    end else begin
                        acc_d    = acc_sum;
                        sticky_d = sticky_q | ovf_ab | ovf_acc;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        for (int k = 0; k < NS; k++) begin
            stage_vld[k] = (av_q[k] != 2'b00) || (vv_q[k] != 2'b00);
        end
    end

    // A stage may load whenever it holds a bubble or its successor is moving.
    always_comb begin
        logic rdy;
        rdy             = !stage_vld[LAST] || i_ready;
        stage_rdy       = '0;
        stage_rdy[LAST] = rdy;
        for (int k = LAST - 1; k >= 0; k--) begin
            rdy          = !stage_vld[k] || rdy;
            stage_rdy[k] = rdy;
        end
    end

    always_comb begin
        for (int k = 0; k < NS; k++) begin
            add_d[k] = add_q[k];
            vn_d[k]  = vn_q[k];
            av_d[k]  = av_q[k];
            vv_d[k]  = vv_q[k];
            ovf_d[k] = ovf_q[k];
        end
        if (stage_rdy[0]) begin
            add_d[0] = in_add;
            vn_d[0]  = in_vn;
            av_d[0]  = in_av;
            vv_d[0]  = in_vv;
            ovf_d[0] = in_ovf;
        end
        for (int k = 1; k < NS; k++) begin
            if (stage_rdy[k]) begin
                add_d[k] = add_q[k-1];
                vn_d[k]  = vn_q[k-1];
                av_d[k]  = av_q[k-1];
                vv_d[k]  = vv_q[k-1];
                ovf_d[k] = ovf_q[k-1];
            end
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            sticky_q <= 1'b0;
            ovf_q    <= '0;
            for (int k = 0; k < NS; k++) begin
                add_q[k] <= '0;
                vn_q[k]  <= '0;
                av_q[k]  <= '0;
                vv_q[k]  <= '0;
            end
        end else begin
            acc_q    <= acc_d;
            sticky_q <= sticky_d;
            ovf_q    <= ovf_d;
            for (int k = 0; k < NS; k++) begin
                add_q[k] <= add_d[k];
                vn_q[k]  <= vn_d[k];
                av_q[k]  <= av_d[k];
                vv_q[k]  <= vv_d[k];
            end
        end
    end

    assign o_valid       = stage_vld[LAST];
    assign o_ready       = stage_rdy[LAST];
    assign o_adder       = add_q[LAST];
    assign o_adder_valid = av_q[LAST];
    assign o_vn          = vn_q[LAST];
    assign o_vn_valid    = vv_q[LAST];
    assign o_ovf         = ovf_q[LAST];

endmodule

// File: tb/tb_pipelined_adder_switch.sv
// Directed bench for pipelined_adder_switch; ADD_LAT=1 and 8 copies share the input stream.
module tb_pipelined_adder_switch;

    logic         CLK = 1'b0;
    logic         rst_n;
    logic         i_valid;
    logic [127:0] i_data_bus;
    logic [1:0]   i_sel_l, i_sel_r;
    logic [2:0]   i_cmd;
    logic         i_last;
    logic         i_ready;

    logic        o_ready, o_valid, o_ovf;
    logic [63:0] o_adder, o_vn;
    logic [1:0]  o_adder_valid, o_vn_valid;

    logic        d1_ready, d1_valid, d1_ovf;
    logic [63:0] d1_adder, d1_vn;
    logic [1:0]  d1_av, d1_vv;
    logic        d8_ready, d8_valid, d8_ovf;
    logic [63:0] d8_adder, d8_vn;
    logic [1:0]  d8_av, d8_vv;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    localparam int N = 24;
    logic [31:0] sa [N];
    logic [31:0] sb [N];
    logic [31:0] e;
    logic        eo;

    always #5 CLK = ~CLK;

    pipelined_adder_switch #(.ADD_LAT(2)) u_dut (
        .CLK(CLK), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_data_bus(i_data_bus), .i_sel_l(i_sel_l), .i_sel_r(i_sel_r), .i_cmd(i_cmd),
        .i_last(i_last), .o_valid(o_valid), .i_ready(i_ready), .o_adder(o_adder),
        .o_adder_valid(o_adder_valid), .o_vn(o_vn), .o_vn_valid(o_vn_valid), .o_ovf(o_ovf)
    );

    pipelined_adder_switch #(.ADD_LAT(1)) u_dut1 (
        .CLK(CLK), .rst_n(rst_n), .i_valid(i_valid), .o_ready(d1_ready),
        .i_data_bus(i_data_bus), .i_sel_l(i_sel_l), .i_sel_r(i_sel_r), .i_cmd(i_cmd),
        .i_last(i_last), .o_valid(d1_valid), .i_ready(i_ready), .o_adder(d1_adder),
        .o_adder_valid(d1_av), .o_vn(d1_vn), .o_vn_valid(d1_vv), .o_ovf(d1_ovf)
    );

    pipelined_adder_switch #(.ADD_LAT(8)) u_dut8 (
        .CLK(CLK), .rst_n(rst_n), .i_valid(i_valid), .o_ready(d8_ready),
        .i_data_bus(i_data_bus), .i_sel_l(i_sel_l), .i_sel_r(i_sel_r), .i_cmd(i_cmd),
        .i_last(i_last), .o_valid(d8_valid), .i_ready(i_ready), .o_adder(d8_adder),
        .o_adder_valid(d8_av), .o_vn(d8_vn), .o_vn_valid(d8_vv), .o_ovf(d8_ovf)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [63:0] add,
                              input logic [1:0] av, input logic [63:0] vn, input logic [1:0] vv,
                              input logic ovf);
        check({tag, ".valid"}, 64'(o_valid), 64'(v));
        check({tag, ".adder"}, o_adder, add);
        check({tag, ".adder_valid"}, 64'(o_adder_valid), 64'(av));
        check({tag, ".vn"}, o_vn, vn);
        check({tag, ".vn_valid"}, 64'(o_vn_valid), 64'(vv));
        check({tag, ".ovf"}, 64'(o_ovf), 64'(ovf));
    endtask

    task automatic drive(input logic [2:0] cmd, input int sl, input int sr,
                         input logic [31:0] a, input logic [31:0] b, input logic last);
        for (int k = 0; k < 4; k++) i_data_bus[k*32 +: 32] = 32'hDEAD_0000 + 32'(k);
        i_data_bus[sl*32 +: 32] = a;
        i_data_bus[sr*32 +: 32] = b;
        i_sel_l = 2'(sl);
        i_sel_r = 2'(sr);
        i_cmd   = cmd;
        i_last  = last;
        i_valid = 1'b1;
    endtask

    task automatic idle();
        i_valid = 1'b0;
        i_cmd   = 3'b000;
        i_last  = 1'b0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        i_ready    = 1'b1;
        i_data_bus = '0;
        i_sel_l    = '0;
        i_sel_r    = '0;
        idle();
        #2;
        expect_out("rst", 1'b0, 64'd0, 2'b00, 64'd0, 2'b00, 1'b0);
        check("rst.o_ready", 64'(o_ready), 64'd1);
        #10 rst_n = 1'b1;
        tick();
        check("rel.o_ready", 64'(o_ready), 64'd1);

        // Plain add with latency check
        drive(3'b010, 0, 3, 32'd5, 32'd7, 1'b0);
        tick();
        idle();
        check("add.lat0", 64'(o_valid), 64'd0);
        tick();
        check("add.lat1", 64'(o_valid), 64'd0);
        tick();
        expect_out("add", 1'b1, {32'd12, 32'd12}, 2'b11, 64'd0, 2'b00, 1'b0);
        tick();
        check("add.drain", 64'(o_valid), 64'd0);

        // Signed overflow
        drive(3'b010, 0, 3, 32'h7FFF_FFFF, 32'd1, 1'b0);
        tick();
        idle();
        tick();
        tick();
        expect_out("ovf", 1'b1, {32'h8000_0000, 32'h8000_0000}, 2'b11, 64'd0, 2'b00, 1'b1);
        tick();

        // Accumulation group 3+4+5 with an interleaved VN beat
        drive(3'b110, 0, 3, 32'd1, 32'd2, 1'b0);
        tick();
        drive(3'b101, 2, 1, 32'hA, 32'hB, 1'b0);
        tick();
        drive(3'b110, 1, 2, 32'd4, 32'd0, 1'b0);
        tick();
        check("acc.bubble0", 64'(o_valid), 64'd0);
        drive(3'b110, 3, 0, 32'd2, 32'd3, 1'b1);
        tick();
        idle();
        expect_out("acc.vn", 1'b1, 64'd0, 2'b00, {32'hA, 32'hB}, 2'b11, 1'b0);
        tick();
        check("acc.bubble1", 64'(o_valid), 64'd0);
        tick();
        expect_out("acc.sum", 1'b1, {32'd12, 32'd12}, 2'b11, 64'd0, 2'b00, 1'b0);
        drive(3'b110, 0, 3, 32'd1, 32'd0, 1'b1);
        tick();
        idle();
        tick();
        tick();
        expect_out("acc.new", 1'b1, {32'd1, 32'd1}, 2'b11, 64'd0, 2'b00, 1'b0);
        tick();

        // Back-to-back forwards with a 3-cycle downstream stall
        drive(3'b001, 2, 1, 32'd11, 32'd22, 1'b0);
        tick();
        drive(3'b011, 2, 1, 32'd33, 32'd44, 1'b0);
        tick();
        drive(3'b100, 2, 1, 32'd55, 32'd66, 1'b0);
        tick();
        drive(3'b101, 2, 1, 32'd77, 32'd88, 1'b0);
        i_ready = 1'b0;
        #1;
        check("stall.o_ready", 64'(o_ready), 64'd0);
        expect_out("b0", 1'b1, {32'd11, 32'd22}, 2'b11, 64'd0, 2'b00, 1'b0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("stall.o_ready_h", 64'(o_ready), 64'd0);
            expect_out("b0.hold", 1'b1, {32'd11, 32'd22}, 2'b11, 64'd0, 2'b00, 1'b0);
        end
        i_ready = 1'b1;
        tick();
        idle();
        expect_out("b1", 1'b1, {32'd0, 32'd44}, 2'b01, {32'd0, 32'd33}, 2'b01, 1'b0);
        tick();
        expect_out("b2", 1'b1, {32'd55, 32'd0}, 2'b10, {32'd66, 32'd0}, 2'b10, 1'b0);
        tick();
        expect_out("b3", 1'b1, 64'd0, 2'b00, {32'd77, 32'd88}, 2'b11, 1'b0);
        tick();
        check("b.drain", 64'(o_valid), 64'd0);

        // Reset mid-group with beats in flight
        drive(3'b110, 0, 3, 32'd4, 32'd5, 1'b0);
        tick();
        drive(3'b010, 0, 3, 32'd1, 32'd1, 1'b0);
        tick();
        drive(3'b010, 0, 3, 32'd2, 32'd2, 1'b0);
        tick();
        idle();
        tick();
        check("mid.inflight", o_adder, {32'd2, 32'd2});
        rst_n = 1'b0;
        #1;
        expect_out("mid.rst", 1'b0, 64'd0, 2'b00, 64'd0, 2'b00, 1'b0);
        tick();
        expect_out("mid.rst_edge", 1'b0, 64'd0, 2'b00, 64'd0, 2'b00, 1'b0);
        #2 rst_n = 1'b1;
        tick();
        check("mid.o_ready", 64'(o_ready), 64'd1);
        drive(3'b110, 0, 3, 32'd1, 32'd0, 1'b1);
        tick();
        idle();
        tick();
        check("mid.lat", 64'(o_valid), 64'd0);
        tick();
        expect_out("mid.acc", 1'b1, {32'd1, 32'd1}, 2'b11, 64'd0, 2'b00, 1'b0);
        for (int c = 0; c < 10; c++) tick();

        // Continuous stream at full rate for ADD_LAT 1, 2 and 8
        for (int j = 0; j < N; j++) begin
            sa[j] = $urandom;
            sb[j] = $urandom;
        end
        sa[3] = 32'h7FFF_FFF0;
        sb[3] = 32'h0000_0100;
        for (int j = 0; j < N + 8; j++) begin
            if (j < N) begin
                int sl;
                sl = int'($urandom_range(0, 3));
                drive(3'b010, sl, (sl + 1 + int'($urandom_range(0, 2))) % 4, sa[j], sb[j], 1'b0);
                #0;
                check("str.o_ready", 64'(o_ready), 64'd1);
            end else begin
                idle();
            end
            tick();
            if (j >= 1 && j - 1 < N) begin
                e = sa[j-1] + sb[j-1];
                check("str1.valid", 64'(d1_valid), 64'd1);
                check("str1.sum", d1_adder, {e, e});
            end
            if (j >= 2 && j - 2 < N) begin
                e  = sa[j-2] + sb[j-2];
                eo = (sa[j-2][31] == sb[j-2][31]) && (e[31] != sa[j-2][31]);
                check("str2.valid", 64'(o_valid), 64'd1);
                check("str2.sum", o_adder, {e, e});
                check("str2.ovf", 64'(o_ovf), 64'(eo));
            end
            if (j >= 8 && j - 8 < N) begin
                e = sa[j-8] + sb[j-8];
                check("str8.valid", 64'(d8_valid), 64'd1);
                check("str8.sum", d8_adder, {e, e});
            end
        end
        tick();
        check("str8.drain", 64'(d8_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipelined_adder_switch.md
# pipelined_adder_switch

Parametrised, pipelined successor to the single-stage adder switch in the reduction network. It selects two operands from an NUM_IN-lane input bus, then adds, forwards or emits them as VN outputs, or accumulates sums across a multi-beat group. Results pass through a fixed ADD_LAT-stage pipeline with a valid/ready handshake and full backpressure. It sits at each node of the adder tree between the distribution stage and the next tree level.

## Interface
- DATA_W, 32, operand width; two's-complement integer.
- NUM_IN, 4, number of lanes on the input bus.
- SEL_W, $clog2(NUM_IN), width of each lane selector.
- ADD_LAT, 2, pipeline depth in stages; legal range 1..8.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  input beat valid.
- o_ready  out  1  switch can accept a beat.
- i_data_bus  in  NUM_IN*DATA_W  input lanes; lane k is bits [k*DATA_W +: DATA_W].
- i_sel_l  in  SEL_W  lane index for left operand A.
- i_sel_r  in  SEL_W  lane index for right operand B.
- i_cmd  in  3  command, see Operation.
- i_last  in  1  closes an accumulation group; meaningful only with cmd 110.
- o_valid  out  1  output beat valid.
- i_ready  in  1  downstream accepts the output beat.
- o_adder  out  2*DATA_W  adder/forward result; upper half is left, lower half is right.
- o_adder_valid  out  2  per-half valid {left,right}.
- o_vn  out  2*DATA_W  VN outputs; upper half is left, lower half is right.
- o_vn_valid  out  2  per-half valid {left,right}.
- o_ovf  out  1  signed overflow occurred in the add or accumulation group that produced the result.

## Operation
- A beat is accepted when i_valid && o_ready. A = lane i_sel_l, B = lane i_sel_r, S = A+B modulo 2^DATA_W.
- Commands:
  - 000 consume, no output.
  - 001 o_adder={A,B}, adder_valid 11.
  - 010 o_adder={S,S}, adder_valid 11.
  - 011 o_vn low=A, vn_valid 01; o_adder low=B, adder_valid 01.
  - 100 o_vn high=B, vn_valid 10; o_adder high=A, adder_valid 10.
  - 101 o_vn={A,B}, vn_valid 11.
  - 110 accumulate.
  - 111 reserved; treated as 000.
- Fields whose valid bit is 0 drive zero.
- Accumulate, evaluated at accept:
  - i_last=0: acc <= acc+S; sticky ovf accumulates. The beat enters the pipeline as a bubble with no output.
  - i_last=1: result R = acc+S is emitted as o_adder={R,R}, adder_valid 11, o_ovf = sticky | overflow of this add. acc and sticky then clear to 0.
  - Non-110 beats leave acc and sticky untouched, so groups may interleave with other commands.
- o_ovf: set when operand signs are equal and the result sign differs; 0 for commands other than 010/110.
- A beat whose valid flags are all zero (000, 111, non-last 110) never raises o_valid.

## Timing
- Reset (async assert, sync release) clears:
  - all pipeline stage valids, acc and sticky ovf;
  - o_valid=0, o_adder=0, o_adder_valid=0, o_vn=0, o_vn_valid=0, o_ovf=0.
  - o_ready=1 from the first edge after release.
- Reset mid-group discards the partial sum and all in-flight beats.
- Latency: a beat accepted at edge t is presented on the outputs after edge t+ADD_LAT when not stalled. All commands have identical latency; order is preserved.
- Throughput is one beat per cycle. All outputs are registered.
- Stall: advance = !o_valid || i_ready. o_ready = advance. When advance=0 every stage holds and the outputs stay stable.
- Bubbles are squeezed: a stage holding no output beat may be overwritten even while the last stage is stalled.
- o_valid && !i_ready: o_adder, o_vn, the valid vectors and o_ovf must not change until the handshake completes.
- Accept and emit in the same cycle are legal and sustain full rate.

## Test plan
1. Reset, then cmd 010 with lane0=5, lane3=7, sel_l=0, sel_r=3 -> after ADD_LAT cycles o_valid=1, o_adder={12,12}, adder_valid 11, o_ovf=0.
2. cmd 010 with A=0x7FFFFFFF, B=1 -> o_adder={0x80000000, 0x80000000}, o_ovf=1.
3. cmd 110 beats S=3,4,5, the last with i_last=1, with a cmd 101 beat between them -> exactly two output beats, in order: VN beat first, then o_adder={12,12}. Next group starts from acc=0.
4. Back-to-back cmds 001,011,100,101 with i_ready low for 3 cycles mid-stream -> o_ready drops, outputs hold stable, all four beats appear in order with the correct valid vectors (11/00, 01/01, 10/10, 00/11 as adder/vn) and no loss or duplication.
5. Assert rst_n low mid-group (acc=9) with 2 beats in flight -> outputs zero immediately. After release a cmd 110 with i_last=1 and S=1 yields o_adder={1,1}.
6. Sweep ADD_LAT=1 and 8 with a continuous random stream against a reference model -> cycle-exact latency match, 100% throughput when i_ready is held high.
